// File: rtl/sd_pkg.sv
// Shared SD CMD-line definitions: frame geometry, CRC7 polynomial, engine states.
package sd_pkg;

    localparam int unsigned CMD_FRAME_LEN = 48;
    localparam int unsigned CMD_HDR_LEN   = 40;
    localparam int unsigned CNT_W         = 7;
    localparam logic [6:0]  CRC7_POLY     = 7'h09;

    localparam logic START_BIT   = 1'b0;
    localparam logic TX_BIT_HOST = 1'b1;
    localparam logic TX_BIT_CARD = 1'b0;
    localparam logic END_BIT     = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_WAIT,
        ST_SEND
    } sd_state_e;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first data, clear has priority over enable.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       fb;

    always_comb begin
        crc_d = crc_q;
        fb    = bit_i ^ crc_q[6];
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_card_cmd.sv
// Card-side SD CMD engine: receives host command frames and sends card responses,
// with the SD clock oversampled in the iclk domain.
module sd_card_cmd
    import sd_pkg::*;
#(
    parameter int unsigned NCR_MIN = 2,
    parameter int unsigned NCR_MAX = 64
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        iclk_sd,
    input  logic        icmd_sd,
    output logic        ocmd_sd,
    output logic        ocmd_oe,
    output logic        ocmd_valid,
    output logic        ocmd_err,
    output logic [5:0]  ocmd_index,
    output logic [31:0] ocmd_arg,
    input  logic        iresp_start,
    input  logic [5:0]  iresp_index,
    input  logic [31:0] iresp_arg,
    output logic        oresp_done,
    output logic        obusy
);

    sd_state_e        state_q, state_d;
    logic             clk_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, nxt_cnt;
    logic [44:0]      rx_q, rx_d;
    logic [39:0]      tx_q, tx_d;
    logic             req_q, req_d;
    logic             sd_q, sd_d;
    logic             oe_q, oe_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [5:0]       index_q, index_d;
    logic [31:0]      arg_q, arg_d;
    logic             rise, fall;
    logic             crc_clr, crc_en, crc_bit;
    logic [6:0]       crc_w;

    assign rise    = iclk_sd & ~clk_q;
    assign fall    = ~iclk_sd & clk_q;
    assign nxt_cnt = cnt_q + CNT_W'(1);

    // One CRC instance serves both directions; RX and TX never overlap.
    sd_crc7 u_crc (
        .clk_i (iclk),
        .rst_i (irst),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (crc_bit),
        .crc_o (crc_w)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        req_d   = req_q;
        sd_d    = sd_q;
        oe_d    = oe_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        done_d  = 1'b0;
        index_d = index_q;
        arg_d   = arg_q;
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        crc_bit = icmd_sd;

        case (state_q)
            ST_IDLE: begin
                crc_clr = 1'b1;
                if (rise && (icmd_sd == START_BIT)) begin
                    state_d = ST_RECV;
                    cnt_d   = CNT_W'(1);
                    rx_d    = {rx_q[43:0], icmd_sd};
                end
            end
            ST_RECV: begin
                if (rise) begin
                    rx_d   = {rx_q[43:0], icmd_sd};
                    cnt_d  = nxt_cnt;
                    crc_en = (cnt_q < CNT_W'(CMD_HDR_LEN));
                    if ((cnt_q == CNT_W'(1)) && (icmd_sd != TX_BIT_HOST)) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_W'(CMD_FRAME_LEN - 1)) begin
                        // rx_q now holds frame bits 2..46; icmd_sd is the end bit
                        index_d = rx_q[44:39];
                        arg_d   = rx_q[38:7];
                        cnt_d   = '0;
                        if ((crc_w == rx_q[6:0]) && (icmd_sd == END_BIT)) begin
                            valid_d = 1'b1;
                            state_d = ST_WAIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_WAIT: begin
                crc_clr = 1'b1;
                if (iresp_start && !req_q) begin
                    req_d = 1'b1;
                    tx_d  = {START_BIT, TX_BIT_CARD, iresp_index, iresp_arg};
                end
                if (fall) begin
                    cnt_d = nxt_cnt;
                    if (req_q && (nxt_cnt >= CNT_W'(NCR_MIN))) begin
                        state_d = ST_SEND;
                        oe_d    = 1'b1;
                        sd_d    = tx_q[39];
                        tx_d    = {tx_q[38:0], 1'b0};
                        cnt_d   = '0;
                        req_d   = 1'b0;
                    end else if (nxt_cnt >= CNT_W'(NCR_MAX)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        req_d   = 1'b0;
                    end
                end
            end
            ST_SEND: begin
                if (fall) begin
                    cnt_d = nxt_cnt;
                    if (cnt_q == CNT_W'(CMD_FRAME_LEN - 1)) begin
                        oe_d    = 1'b0;
                        sd_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (nxt_cnt < CNT_W'(CMD_HDR_LEN)) begin
                        sd_d    = tx_q[39];
                        tx_d    = {tx_q[38:0], 1'b0};
                        crc_en  = 1'b1;
                        crc_bit = tx_q[39];
                    end else if (nxt_cnt < CNT_W'(CMD_FRAME_LEN - 1)) begin
                        sd_d = crc_w[3'(CNT_W'(CMD_FRAME_LEN - 2) - nxt_cnt)];
                    end else begin
                        sd_d = END_BIT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    // SD clock sampler: tracks the line through reset so no false edge follows it.
    always_ff @(posedge iclk) begin
        clk_q <= iclk_sd;
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            req_q   <= 1'b0;
            sd_q    <= 1'b1;
            oe_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            index_q <= '0;
            arg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            req_q   <= req_d;
            sd_q    <= sd_d;
            oe_q    <= oe_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            index_q <= index_d;
            arg_q   <= arg_d;
        end
    end

    assign ocmd_sd    = sd_q;
    assign ocmd_oe    = oe_q;
    assign ocmd_valid = valid_q;
    assign ocmd_err   = err_q;
    assign oresp_done = done_q;
    assign obusy      = busy_q;
    assign ocmd_index = index_q;
    assign ocmd_arg   = arg_q;

endmodule

// File: tb/tb_sd_card_cmd.sv
// Bench for sd_card_cmd: directed vector table, random frames against a frame-level
// model, and a reset-during-response sequence.
module tb_sd_card_cmd;

    localparam int NCR_MIN = 2;
    localparam int NCR_MAX = 64;
    localparam int MAXK    = 256;

    logic        iclk = 1'b0;
    logic        irst;
    logic        iclk_sd;
    logic        icmd_sd;
    logic        ocmd_sd;
    logic        ocmd_oe;
    logic        ocmd_valid;
    logic        ocmd_err;
    logic [5:0]  ocmd_index;
    logic [31:0] ocmd_arg;
    logic        iresp_start;
    logic [5:0]  iresp_index;
    logic [31:0] iresp_arg;
    logic        oresp_done;
    logic        obusy;

    always #5 iclk = ~iclk;

    sd_card_cmd #(.NCR_MIN(NCR_MIN), .NCR_MAX(NCR_MAX)) dut (
        .iclk        (iclk),
        .irst        (irst),
        .iclk_sd     (iclk_sd),
        .icmd_sd     (icmd_sd),
        .ocmd_sd     (ocmd_sd),
        .ocmd_oe     (ocmd_oe),
        .ocmd_valid  (ocmd_valid),
        .ocmd_err    (ocmd_err),
        .ocmd_index  (ocmd_index),
        .ocmd_arg    (ocmd_arg),
        .iresp_start (iresp_start),
        .iresp_index (iresp_index),
        .iresp_arg   (iresp_arg),
        .oresp_done  (oresp_done),
        .obusy       (obusy)
    );

    typedef struct {
        logic [47:0] frame;
        int          nbits;
        int          req_k;
        logic [5:0]  ridx;
        logic [31:0] rarg;
        int          e_valid;
        int          e_err;
        logic [5:0]  e_idx;
        logic [31:0] e_arg;
        int          e_fs;
        logic [47:0] e_resp;
        int          e_busy_end;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int          n_valid  = 0;
    int          n_err    = 0;
    int          n_done   = 0;
    int          pulse_k  = -1;
    int          cur_k    = 0;
    logic [5:0]  cap_idx  = '0;
    logic [31:0] cap_arg  = '0;
    logic        oe_log   [MAXK];
    logic        sd_log   [MAXK];
    logic        busy_log [MAXK];
    vec_t        vecs     [7];

    // Pulse monitor: counts one-cycle strobes and captures fields alongside them.
    always @(negedge iclk) begin
        if (ocmd_valid || ocmd_err) begin
            pulse_k = cur_k;
            cap_idx = ocmd_index;
            cap_arg = ocmd_arg;
        end
        if (ocmd_valid) n_valid++;
        if (ocmd_err)   n_err++;
        if (oresp_done) n_done++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // CRC7 by polynomial long division of msg * x^7 by x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] resp_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] hdr;
        hdr = {2'b00, idx, arg};
        return {hdr, crc7_ref(hdr), 1'b1};
    endfunction

    // One SD clock: rise carrying bit b, optional request pulse, then fall and sample.
    task automatic sd_clock(input int k, input logic b, input int req_k,
                            input logic [5:0] ridx, input logic [31:0] rarg);
        int h;
        int l;
        h = int'($urandom_range(4, 2));
        l = int'($urandom_range(4, 2));
        cur_k   = k;
        icmd_sd = b;
        iclk_sd = 1'b1;
        @(negedge iclk);
        if (k == req_k) begin
            iresp_index = ridx;
            iresp_arg   = rarg;
            iresp_start = 1'b1;
        end
        @(negedge iclk);
        iresp_start = 1'b0;
        repeat (h - 2) @(negedge iclk);
        iclk_sd = 1'b0;
        repeat (l) @(negedge iclk);
        oe_log[k]   = ocmd_oe;
        sd_log[k]   = ocmd_sd;
        busy_log[k] = obusy;
    endtask

    task automatic run_vec(input string name, input vec_t v, input int nclk_lim);
        int nclk;
        int v0, e0, d0, e_done, mism, first, f;
        logic eo, es, eb, b;
        if (nclk_lim > 0) nclk = nclk_lim;
        else if (v.e_fs > 0) nclk = 46 + v.e_fs + 50;
        else nclk = (v.req_k + 3 > 114) ? v.req_k + 3 : 114;
        e_done = (v.e_fs > 0 && (46 + v.e_fs + 48) < nclk) ? 1 : 0;
        v0 = n_valid; e0 = n_err; d0 = n_done;
        for (int k = 0; k < nclk; k++) begin
            b = (k < v.nbits) ? v.frame[47 - k] : 1'b1;
            sd_clock(k, b, v.req_k, v.ridx, v.rarg);
        end
        chk({name, " valid_pulses"}, n_valid - v0, v.e_valid);
        chk({name, " err_pulses"}, n_err - e0, v.e_err);
        chk({name, " done_pulses"}, n_done - d0, e_done);
        if (v.e_valid + v.e_err > 0) begin
            chk({name, " index"}, cap_idx, v.e_idx);
            chk({name, " arg"}, cap_arg, v.e_arg);
            chk({name, " pulse_clk"}, pulse_k, 47);
        end
        mism  = 0;
        first = -1;
        for (int k = 0; k < nclk; k++) begin
            f  = k - 46;
            eo = (v.e_fs > 0 && f >= v.e_fs && f <= v.e_fs + 47);
            es = eo ? v.e_resp[47 - (f - v.e_fs)] : 1'b1;
            eb = (k < v.e_busy_end);
            if (oe_log[k] !== eo || sd_log[k] !== es || busy_log[k] !== eb) begin
                mism++;
                if (first < 0) first = k;
            end
        end
        chk($sformatf("%s line_bad_clocks first_clk=%0d", name, first), mism, 0);
    endtask

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        vec_t        v;
        logic [5:0]  idx;
        logic [31:0] arg;
        int          sel, p, fs;
        logic        ok;

        //               frame              nb  req  ridx   rarg        val err idx    arg          fs  resp               busy_end
        vecs[0] = '{48'h400000000095, 48,  -1, 6'd0, 32'h0,      1, 0, 6'd0,  32'h0,      0, 48'h0,             110};
        vecs[1] = '{48'h48000001AA87, 48,  47, 6'd8, 32'h1AA,    1, 0, 6'd8,  32'h1AA,    2, 48'h08000001AA13,  96};
        vecs[2] = '{48'h510000000054, 48,  47, 6'd8, 32'h1AA,    0, 1, 6'd17, 32'h0,      0, 48'h0,             47};
        vecs[3] = '{48'h110000000000, 2,   -1, 6'd0, 32'h0,      0, 0, 6'd0,  32'h0,      0, 48'h0,             1};
        vecs[4] = '{48'h48000001AA87, 48,  57, 6'd8, 32'h1AA,    1, 0, 6'd8,  32'h1AA,    11, 48'h08000001AA13, 105};
        vecs[5] = '{48'h48000001AA87, 48, 117, 6'd8, 32'h1AA,    1, 0, 6'd8,  32'h1AA,    0, 48'h0,             110};
        vecs[6] = '{48'h510000000055, 48,  -1, 6'd0, 32'h0,      1, 0, 6'd17, 32'h0,      0, 48'h0,             110};

        irst        = 1'b1;
        iclk_sd     = 1'b0;
        icmd_sd     = 1'b1;
        iresp_start = 1'b0;
        iresp_index = '0;
        iresp_arg   = '0;
        repeat (3) @(negedge iclk);
        chk("reset ocmd_sd", ocmd_sd, 1);
        chk("reset ocmd_oe", ocmd_oe, 0);
        chk("reset obusy", obusy, 0);
        chk("reset strobes", {ocmd_valid, ocmd_err, oresp_done}, 0);
        chk("reset index_arg", {ocmd_index, ocmd_arg}, 0);
        irst = 1'b0;
        repeat (2) @(negedge iclk);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], 0);
        end

        // Reset while response bit 20 is on the line, then a fresh command.
        run_vec("rst_send", vecs[1], 69);
        chk("rst_send pre oe", ocmd_oe, 1);
        irst = 1'b1;
        @(negedge iclk);
        chk("rst_send ocmd_oe", ocmd_oe, 0);
        chk("rst_send ocmd_sd", ocmd_sd, 1);
        chk("rst_send obusy", obusy, 0);
        irst = 1'b0;
        @(negedge iclk);
        run_vec("after_rst", vecs[6], 0);

        for (int t = 0; t < 24; t++) begin
            idx = 6'($urandom);
            arg = $urandom;
            v.frame = {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
            v.nbits = 48;
            sel = int'($urandom_range(7, 0));
            if (sel == 0) begin
                v.frame[46] = 1'b0;
                v.nbits     = 2;
            end else if (sel <= 2) begin
                p = int'($urandom_range(47, 2));
                v.frame[47 - p] = ~v.frame[47 - p];
            end
            v.req_k = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(120, 40));
            v.ridx  = 6'($urandom);
            v.rarg  = $urandom;
            v.e_valid = 0; v.e_err = 0; v.e_fs = 0; v.e_resp = '0;
            v.e_idx = v.frame[45:40];
            v.e_arg = v.frame[39:8];
            if (v.frame[46] == 1'b0) begin
                v.e_busy_end = 1;
            end else begin
                ok = (crc7_ref(v.frame[47:8]) == v.frame[7:1]) && v.frame[0];
                if (!ok) begin
                    v.e_err      = 1;
                    v.e_busy_end = 47;
                end else begin
                    v.e_valid = 1;
                    if (v.req_k >= 47 && v.req_k - 46 <= NCR_MAX) begin
                        fs = (v.req_k - 46 > NCR_MIN) ? v.req_k - 46 : NCR_MIN;
                        v.e_fs       = fs;
                        v.e_resp     = resp_frame(v.ridx, v.rarg);
                        v.e_busy_end = 46 + fs + 48;
                    end else begin
                        v.e_busy_end = 46 + NCR_MAX;
                    end
                end
            end
            run_vec($sformatf("rnd%0d", t), v, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
